// File: rtl/prism_pkg.sv
// Shared widths, FSM encoding and small arithmetic helpers for the spectrum
// band accumulator.
package prism_pkg;

    localparam int MAG_W = 16;

    typedef enum logic [1:0] {
        ST_ACC    = 2'd0,
        ST_COMMIT = 2'd1,
        ST_SWAP   = 2'd2
    } state_e;

    // Ceiling log2 usable in constant expressions; clog2_fn(1) == 0.
    function automatic int clog2_fn(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic logic [MAG_W-1:0] sat_sub(input logic [MAG_W-1:0] a,
                                                 input logic [MAG_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/spectrum_band_accum_band_reduce.sv
// Per-band accumulator: folds bins into a running max or sum and presents the
// band result combinationally on the bin that flushes the band.
module band_reduce
    import prism_pkg::*;
#(
    parameter int BPB       = 8,
    parameter int MEAN_MODE = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [MAG_W-1:0] data_i,
    output logic [MAG_W-1:0] result_o
);

    localparam int SHIFT = clog2_fn(BPB);
    // Wide enough for BPB full-scale bins without overflow.
    localparam int ACC_W = MAG_W + SHIFT;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] data_ext;
    logic [ACC_W-1:0] merged;

    // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
    always_comb begin
        data_ext = ACC_W'(data_i);
        merged   = acc_q;
        if (MEAN_MODE != 0) begin
            merged = acc_q + data_ext;
        end else if (data_ext > acc_q) begin
            merged = data_ext;
        end

        // A short (early-terminated) band still divides by the full BPB.
        if (MEAN_MODE != 0) begin
            result_o = MAG_W'(merged >> SHIFT);
        end else begin
            result_o = MAG_W'(merged);
        end

        acc_d = acc_q;
        if (clr_i || (valid_i && flush_i)) begin
            acc_d = '0;
        end else if (valid_i) begin
            acc_d = merged;
        end
    end

    // NOTE: sequential state uses non-blocking <= so all flops sample pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/spectrum_band_accum.sv
// Reduces a streamed FFT magnitude frame to BANDS bands with peak-fall decay,
// double-buffers the result and serves the front bank on a registered read port.
module spectrum_band_accum
    import prism_pkg::*;
#(
    parameter int          FFT_BINS  = 256,
    parameter int          BANDS     = 32,
    parameter int          MEAN_MODE = 0,
    parameter logic [15:0] DECAY     = 16'd512
) (
    input  logic                     clk_50m,
    input  logic                     rst,
    input  logic [15:0]              mag_data,
    input  logic                     mag_valid,
    input  logic                     mag_last,
    output logic                     mag_ready,
    input  logic                     spec_rd_en,
    input  logic [$clog2(BANDS)-1:0] spec_rd_addr,
    output logic [15:0]              spec_rd_data,
    output logic                     spec_rd_data_valid,
    output logic                     spec_frame_stb,
    output logic                     frame_err
);

    localparam int BPB    = FFT_BINS / BANDS;
    localparam int BPB_W  = clog2_fn(BPB);
    localparam int BIN_W  = clog2_fn(FFT_BINS);
    localparam int BAND_W = clog2_fn(BANDS);

    state_e            state_q;
    logic [BIN_W-1:0]  bin_cnt_q;
    logic [BAND_W-1:0] commit_idx_q;
    logic              sel_q;
    logic              mag_ready_q;
    logic              stb_q;
    logic              err_q;
    logic [MAG_W-1:0]  rd_data_q;
    logic              rd_valid_q;

    logic [MAG_W-1:0]  stage_q [BANDS];
    logic [MAG_W-1:0]  bank_q  [2][BANDS];

    logic              accept;
    logic              at_last_bin;
    logic              band_full;
    logic              frame_end;
    logic              flush;
    logic              length_bad;
    logic [BAND_W-1:0] cur_band;
    logic [MAG_W-1:0]  band_result;
    logic [MAG_W-1:0]  decayed;
    logic [MAG_W-1:0]  commit_d;

    always_comb begin
        accept      = mag_valid && mag_ready_q;
        at_last_bin = (bin_cnt_q == BIN_W'(FFT_BINS - 1));
        band_full   = ((bin_cnt_q & BIN_W'(BPB - 1)) == BIN_W'(BPB - 1));
        frame_end   = accept && (mag_last || at_last_bin);
        flush       = accept && (band_full || frame_end);
        length_bad  = frame_end && !(mag_last && at_last_bin);
        cur_band    = BAND_W'(bin_cnt_q >> BPB_W);

        // Back bank entry = fresh band value, or the old front falling by at most DECAY.
        decayed  = sat_sub(bank_q[sel_q][commit_idx_q], DECAY);
        commit_d = (stage_q[commit_idx_q] > decayed) ? stage_q[commit_idx_q] : decayed;
    end

    band_reduce #(
        .BPB       (BPB),
        .MEAN_MODE (MEAN_MODE)
    ) u_band_reduce (
        .clk_i    (clk_50m),
        .rst_i    (rst),
        .clr_i    (state_q == ST_SWAP),
        .valid_i  (accept),
        .flush_i  (flush),
        .data_i   (mag_data),
        .result_o (band_result)
    );

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q      <= ST_ACC;
            bin_cnt_q    <= '0;
            commit_idx_q <= '0;
            sel_q        <= 1'b0;
            mag_ready_q  <= 1'b1;
            stb_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        bin_cnt_q <= bin_cnt_q + 1'b1;
                        if (frame_end) begin
                            state_q      <= ST_COMMIT;
                            mag_ready_q  <= 1'b0;
                            commit_idx_q <= '0;
                            err_q        <= length_bad;
                        end
                    end
                end
                ST_COMMIT: begin
                    commit_idx_q <= commit_idx_q + 1'b1;
                    if (commit_idx_q == BAND_W'(BANDS - 1)) begin
                        state_q <= ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    sel_q       <= ~sel_q;
                    stb_q       <= 1'b1;
                    mag_ready_q <= 1'b1;
                    bin_cnt_q   <= '0;
                    state_q     <= ST_ACC;
                end
                default: begin
                    state_q     <= ST_ACC;
                    mag_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // NOTE: the banks are plain flop arrays and are explicitly reset so a reset always reads back zero.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            for (int b = 0; b < BANDS; b++) begin
                stage_q[b]   <= '0;
                bank_q[0][b] <= '0;
                bank_q[1][b] <= '0;
            end
        end else begin
            if (flush) begin
                stage_q[cur_band] <= band_result;
            end
            // Cleared at the swap so bands an early mag_last never reaches stage as 0.
            if (state_q == ST_SWAP) begin
                for (int b = 0; b < BANDS; b++) begin
                    stage_q[b] <= '0;
                end
            end
            if (state_q == ST_COMMIT) begin
                bank_q[~sel_q][commit_idx_q] <= commit_d;
            end
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= spec_rd_en;
            if (spec_rd_en) begin
                rd_data_q <= bank_q[sel_q][spec_rd_addr];
            end
        end
    end

    assign mag_ready          = mag_ready_q;
    assign spec_rd_data       = rd_data_q;
    assign spec_rd_data_valid = rd_valid_q;
    assign spec_frame_stb     = stb_q;
    assign frame_err          = err_q;

endmodule

// File: tb/tb_spectrum_band_accum.sv
// Directed bench: a max-mode and a mean-mode instance share stimulus; read
// results are checked against a scoreboard fed by a behavioural band model.
module tb_spectrum_band_accum;

    localparam int NB  = 256;
    localparam int NBD = 32;

    typedef struct {
        int v0;
        int v1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mag_data = '0;
    logic        mag_valid = 1'b0;
    logic        mag_last = 1'b0;
    logic        rd_en = 1'b0;
    logic [4:0]  rd_addr = '0;

    logic        ready_max, ready_mean;
    logic [15:0] data_max, data_mean;
    logic        valid_max, valid_mean;
    logic        stb_max, stb_mean;
    logic        err_max, err_mean;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    int   front_m [2][NBD];
    int   old_f   [2][NBD];

    always #10 clk = ~clk;

    spectrum_band_accum #(.FFT_BINS(NB), .BANDS(NBD), .MEAN_MODE(0), .DECAY(16'd512)) u_dut_max (
        .clk_50m(clk), .rst(rst), .mag_data(mag_data), .mag_valid(mag_valid), .mag_last(mag_last),
        .mag_ready(ready_max), .spec_rd_en(rd_en), .spec_rd_addr(rd_addr), .spec_rd_data(data_max),
        .spec_rd_data_valid(valid_max), .spec_frame_stb(stb_max), .frame_err(err_max));

    spectrum_band_accum #(.FFT_BINS(NB), .BANDS(NBD), .MEAN_MODE(1), .DECAY(16'd512)) u_dut_mean (
        .clk_50m(clk), .rst(rst), .mag_data(mag_data), .mag_valid(mag_valid), .mag_last(mag_last),
        .mag_ready(ready_mean), .spec_rd_en(rd_en), .spec_rd_addr(rd_addr), .spec_rd_data(data_mean),
        .spec_rd_data_valid(valid_mean), .spec_frame_stb(stb_mean), .frame_err(err_mean));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Read-port monitor: every valid beat must match the oldest queued expectation.
    always @(negedge clk) begin
        if (valid_max) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rd_max", 32'(data_max), 32'(e.v0));
                check("rd_mean", 32'(data_mean), 32'(e.v1));
                check("rd_valid_mean", 32'(valid_mean), 32'd1);
            end
        end
    end

    // Behavioural model: bins are index (kind 0) or a constant (kind 1).
    task automatic model_frame(input int kind, input int val, input int nbins);
        for (int m = 0; m < 2; m++) begin
            for (int b = 0; b < NBD; b++) begin
                int cnt, mx, sum, stage, dec, v;
                cnt = 0; mx = 0; sum = 0;
                for (int k = 0; k < NB / NBD; k++) begin
                    int i;
                    i = b * (NB / NBD) + k;
                    if (i < nbins) begin
                        v = (kind == 0) ? i : val;
                        cnt++;
                        sum += v;
                        if (v > mx) mx = v;
                    end
                end
                stage = (cnt == 0) ? 0 : ((m == 1) ? (sum >> 3) : mx);
                dec   = (front_m[m][b] > 512) ? front_m[m][b] - 512 : 0;
                front_m[m][b] = (stage > dec) ? stage : dec;
            end
        end
    endtask

    task automatic clear_model();
        for (int m = 0; m < 2; m++)
            for (int b = 0; b < NBD; b++)
                front_m[m][b] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; mag_valid = 1'b0; mag_last = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_model();
    endtask

    task automatic send_frame(input int kind, input int val, input int nbins, input bit with_last);
        check("ready_at_start", 32'(ready_max), 32'd1);
        for (int i = 0; i < nbins; i++) begin
            mag_valid = 1'b1;
            mag_data  = (kind == 0) ? 16'(i) : 16'(val);
            mag_last  = with_last && (i == nbins - 1);
            @(negedge clk);
        end
        mag_valid = 1'b0;
        mag_last  = 1'b0;
        check("frame_err_max", 32'(err_max), 32'(!(with_last && nbins == NB)));
        check("frame_err_mean", 32'(err_mean), 32'(!(with_last && nbins == NB)));
    endtask

    task automatic wait_stb(input int exp_lat);
        int k;
        for (k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) check("ready_low_commit", 32'(ready_max), 32'd0);
            if (stb_max) break;
        end
        check("stb_latency", 32'(k), 32'(exp_lat));
        check("stb_mean", 32'(stb_mean), 32'd1);
        check("ready_after_swap", 32'(ready_max), 32'd1);
    endtask

    task automatic run_frame(input int kind, input int val, input int nbins, input bit with_last);
        send_frame(kind, val, nbins, with_last);
        model_frame(kind, val, nbins);
        wait_stb(NBD + 1);
    endtask

    task automatic read_all();
        for (int b = 0; b < NBD; b++) begin
            rd_en   = 1'b1;
            rd_addr = 5'(b);
            sb.push_back(exp_t'{front_m[0][b], front_m[1][b]});
            @(negedge clk);
        end
        rd_en = 1'b0;
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic read_one(input int addr, input int e0, input int e1);
        rd_en   = 1'b1;
        rd_addr = 5'(addr);
        sb.push_back(exp_t'{e0, e1});
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        check("sb_drained_one", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #(20 * 90000);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready_max), 32'd1);
        check("rst_stb", 32'(stb_max), 32'd0);
        check("rst_err", 32'(err_max), 32'd0);
        check("rst_valid", 32'(valid_max), 32'd0);
        check("rst_data", 32'(data_max), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        read_all();

        // Ramp frame: max band b = 8b+7, mean band b = 8b+3.
        run_frame(0, 0, NB, 1'b1);
        read_all();
        read_one(3, 31, 27);
        read_one(31, 255, 251);

        // Read every cycle through COMMIT: old bank until the read after the swap edge.
        send_frame(1, 3000, NB, 1'b1);
        old_f = front_m;
        model_frame(1, 3000, NB);
        for (int k = 1; k <= 40; k++) begin
            rd_en   = 1'b1;
            rd_addr = 5'(k % NBD);
            if (k <= NBD + 1) sb.push_back(exp_t'{old_f[0][k % NBD], old_f[1][k % NBD]});
            else              sb.push_back(exp_t'{front_m[0][k % NBD], front_m[1][k % NBD]});
            @(negedge clk);
            check("swap_stb", 32'(stb_max), 32'(k == NBD + 1));
            check("swap_ready", 32'(ready_max), 32'(k >= NBD + 1));
        end
        rd_en = 1'b0;
        @(negedge clk);
        check("sb_drained_swap", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        check("rd_data_hold", 32'(data_max), 32'(front_m[0][8]));

        // Early mag_last at bin 100.
        do_reset();
        run_frame(0, 0, 101, 1'b1);
        read_all();
        read_one(11, 95, 91);
        read_one(12, 100, 61);
        read_one(13, 0, 0);

        // Missing mag_last: frame ends at the last bin anyway, with an error pulse.
        run_frame(1, 500, NB, 1'b0);
        read_all();

        // Mean mode, constant 1000, two identical frames.
        do_reset();
        run_frame(1, 1000, NB, 1'b1);
        read_one(7, 1000, 1000);
        run_frame(1, 1000, NB, 1'b1);
        read_all();

        // Decay from 40000 toward zero without wrapping.
        do_reset();
        run_frame(1, 40000, NB, 1'b1);
        read_one(0, 40000, 40000);
        run_frame(1, 0, NB, 1'b1);
        read_one(5, 39488, 39488);
        run_frame(1, 0, NB, 1'b1);
        read_one(5, 38976, 38976);
        for (int f = 0; f < 76; f++) run_frame(1, 0, NB, 1'b1);
        read_one(9, 64, 64);
        run_frame(1, 0, NB, 1'b1);
        read_one(9, 0, 0);
        run_frame(1, 0, NB, 1'b1);
        read_all();

        // Reset in the middle of a frame: nothing emitted, banks zero, next frame clean.
        run_frame(0, 0, NB, 1'b1);
        for (int i = 0; i < 50; i++) begin
            mag_valid = 1'b1;
            mag_data  = 16'(i);
            @(negedge clk);
        end
        mag_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        begin
            int pulses;
            pulses = 0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                if (stb_max || err_max || stb_mean || err_mean) pulses++;
            end
            check("no_pulse_after_rst", 32'(pulses), 32'd0);
        end
        read_all();
        run_frame(0, 0, NB, 1'b1);
        read_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
